if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the decode stage. Owns the PC and the IF/ID pipeline register, and issues fetches to instruction memory over a request/ready handshake. Obeys the decode stage's stall (WPCIR) and jump/branch redirect. Supplies `id_pc_4` and `id_instruction` to decode.

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage_if.sv | 13 +
 rtl/if_stage_pc_next_select.sv | 29 ++
 rtl/if_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, fetch-state
// codes, next-PC select codes, IF/ID update codes and the default reset PC.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetchState_t;
  localparam fetchState_t ST_RESET = 2'd0;
  localparam fetchState_t ST_FETCH = 2'd1;
  localparam fetchState_t ST_HELD  = 2'd2;
  localparam fetchState_t ST_DRAIN = 2'd3;

  typedef logic [1:0] pcSel_t;
  localparam pcSel_t PC_HOLD    = 2'd0;
  localparam pcSel_t PC_INCR    = 2'd1;
  localparam pcSel_t PC_TARGET  = 2'd2;
  localparam pcSel_t PC_PENDING = 2'd3;

  typedef logic [1:0] ifidOp_t;
  localparam ifidOp_t IFID_HOLD   = 2'd0;
  localparam ifidOp_t IFID_MEM    = 2'd1;
  localparam ifidOp_t IFID_BUF    = 2'd2;
  localparam ifidOp_t IFID_BUBBLE = 2'd3;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_stage_if;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (output imem_request, output imem_address,
                  input  imem_ready,   input  imem_data);
  modport slave  (input  imem_request, input  imem_address,
                  output imem_ready,   output imem_data);
endinterface

// File: rtl/if_stage_pc_next_select.sv
// Combinational next-PC mux: hold, sequential +4, redirect target or the
// target latched while a fetch was outstanding. Also exposes pc+4 for IF/ID.
module pc_next_select
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] jumpOrBranchPc,
  input  logic [31:0] pendingPc,
  input  pcSel_t      pcSel,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPc
);

  // 32-bit modulo increment; wraps from FFFF_FFFC to 0.
  assign pcPlus4 = pc + 32'd4;

  // Select the PC to load on the next edge.
  always_comb begin
    nextPc = pc;
    case (pcSel)
      PC_HOLD:    nextPc = pc;
      PC_INCR:    nextPc = pcPlus4;
      PC_TARGET:  nextPc = jumpOrBranchPc;
      PC_PENDING: nextPc = pendingPc;
      default:    nextPc = pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID register, a one-entry skid
// buffer for responses that land during a decode stall, and a pending-target
// register for redirects that arrive while a fetch is outstanding.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (MIPS delay-slot semantics).
// Without it a redirect squashes the fetched word and waits out any
// outstanding fetch in DRAIN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shouldStall,
  input  logic              shouldJumpOrBranch,
  input  logic [31:0]       jumpOrBranchPc,
  if_stage_if.master        imem,
  output logic [31:0]       id_pc_4,
  output logic [31:0]       id_instruction,
  output logic              id_valid,
  output logic [31:0]       debug_pc
);

  fetchState_t state;
  fetchState_t nextState;
  logic [31:0] pc;
  logic [31:0] nextPc;
  logic [31:0] pcPlus4;
  logic [31:0] skidData;
  logic [31:0] pendingPc;
  logic        pendingValid;
  pcSel_t      pcSel;
  ifidOp_t     ifidOp;
  logic        skidLoad;
  logic        pendingSet;
  logic        pendingClr;
  logic        redirect;

  // Stall wins over redirect; decode re-evaluates the branch after the stall.
  assign redirect = shouldJumpOrBranch & id_valid & ~shouldStall;

  assign imem.imem_address = pc;
  assign imem.imem_request = (state == ST_FETCH) || (state == ST_DRAIN);
  assign debug_pc          = pc;

  pc_next_select uPcNext (
    .pc             (pc),
    .jumpOrBranchPc (jumpOrBranchPc),
    .pendingPc      (pendingPc),
    .pcSel          (pcSel),
    .pcPlus4        (pcPlus4),
    .nextPc         (nextPc)
  );

  // Fetch control: next state, PC source, IF/ID action, buffer updates.
  always_comb begin
    nextState  = state;
    pcSel      = PC_HOLD;
    ifidOp     = IFID_HOLD;
    skidLoad   = 1'b0;
    pendingSet = 1'b0;
    pendingClr = 1'b0;
    case (state)
      ST_RESET: begin
        nextState = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready) begin
          if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
            ifidOp = IFID_MEM;
`else
            ifidOp = IFID_BUBBLE;
`endif
            pcSel = PC_TARGET;
          end else if (shouldStall) begin
            skidLoad  = 1'b1;
            nextState = ST_HELD;
          end else begin
            ifidOp     = IFID_MEM;
            pcSel      = pendingValid ? PC_PENDING : PC_INCR;
            pendingClr = pendingValid;
          end
        end else begin
          if (redirect) begin
            pendingSet = 1'b1;
            ifidOp     = IFID_BUBBLE;
`ifdef BRANCH_DELAY_SLOT_EN
            nextState  = ST_FETCH;
`else
            nextState  = ST_DRAIN;
`endif
          end else if (shouldStall) begin
            ifidOp = IFID_HOLD;
          end else begin
            ifidOp = IFID_BUBBLE;
          end
        end
      end
      ST_HELD: begin
        if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
          ifidOp = IFID_BUF;
`else
          ifidOp = IFID_BUBBLE;
`endif
          pcSel      = PC_TARGET;
          pendingClr = pendingValid;
          nextState  = ST_FETCH;
        end else if (shouldStall) begin
          nextState = ST_HELD;
        end else begin
          ifidOp     = IFID_BUF;
          pcSel      = pendingValid ? PC_PENDING : PC_INCR;
          pendingClr = pendingValid;
          nextState  = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem.imem_ready) begin
          ifidOp     = IFID_BUBBLE;
          pcSel      = PC_PENDING;
          pendingClr = 1'b1;
          nextState  = ST_FETCH;
        end else begin
          nextState = ST_DRAIN;
        end
      end
      default: begin
        nextState = ST_RESET;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RESET;
      pc    <= RESET_PC;
    end else begin
      state <= nextState;
      pc    <= nextPc;
    end
  end

  // Skid buffer and pending redirect target.
  always_ff @(posedge clock) begin
    if (reset) begin
      skidData     <= 32'h0000_0000;
      pendingPc    <= 32'h0000_0000;
      pendingValid <= 1'b0;
    end else begin
      if (skidLoad) begin
        skidData <= imem.imem_data;
      end
      if (pendingSet) begin
        pendingPc    <= jumpOrBranchPc;
        pendingValid <= 1'b1;
      end else if (pendingClr) begin
        pendingValid <= 1'b0;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_pc_4        <= 32'h0000_0000;
      id_instruction <= NOP_INSTR;
      id_valid       <= 1'b0;
    end else begin
      case (ifidOp)
        IFID_MEM: begin
          id_pc_4        <= pcPlus4;
          id_instruction <= imem.imem_data;
          id_valid       <= 1'b1;
        end
        IFID_BUF: begin
          id_pc_4        <= pcPlus4;
          id_instruction <= skidData;
          id_valid       <= 1'b1;
        end
        IFID_BUBBLE: begin
          id_instruction <= NOP_INSTR;
          id_valid       <= 1'b0;
        end
        default: begin
          id_valid <= id_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns {16'hC0DE, addr[15:0]}, and
// ready/stall/branch are stepped one clock at a time against hand-computed
// expectations. Both delay-slot and non-delay builds are covered.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpOrBranchPc;
  logic [31:0] id_pc_4;
  logic [31:0] id_instruction;
  logic        id_valid;
  logic [31:0] debug_pc;

  int checkCount = 0;
  int passCount  = 0;

  if_stage_if imemBus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpOrBranchPc     (jumpOrBranchPc),
    .imem               (imemBus.master),
    .id_pc_4            (id_pc_4),
    .id_instruction     (id_instruction),
    .id_valid           (id_valid),
    .debug_pc           (debug_pc)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  assign imemBus.imem_data = memWord(imemBus.imem_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    shouldStall        = 1'b0;
    shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc     = 32'h0000_0000;
    imemBus.imem_ready = 1'b1;
    tick();
    tick();
    checkVal("rst_req",   32'(imemBus.imem_request), 32'd0);
    checkVal("rst_pc",    debug_pc, 32'h0000_0000);
    checkVal("rst_valid", 32'(id_valid), 32'd0);
    checkVal("rst_instr", id_instruction, 32'h0000_0000);
    checkVal("rst_pc4",   id_pc_4, 32'h0000_0000);

    // Zero-wait streaming: addresses 0,4,8; id_pc_4 4,8,12.
    reset = 1'b0;
    tick();
    checkVal("first_req",  32'(imemBus.imem_request), 32'd1);
    checkVal("first_addr", imemBus.imem_address, 32'h0000_0000);
    tick();
    checkVal("s0_pc4",   id_pc_4, 32'h0000_0004);
    checkVal("s0_instr", id_instruction, 32'hC0DE_0000);
    checkVal("s0_valid", 32'(id_valid), 32'd1);
    checkVal("s0_addr",  imemBus.imem_address, 32'h0000_0004);
    tick();
    checkVal("s1_pc4",  id_pc_4, 32'h0000_0008);
    checkVal("s1_addr", imemBus.imem_address, 32'h0000_0008);
    tick();
    checkVal("s2_pc4",   id_pc_4, 32'h0000_000C);
    checkVal("s2_instr", id_instruction, 32'hC0DE_0008);

    // Stall two cycles while the fetch at 12 completes.
    shouldStall = 1'b1;
    tick();
    checkVal("held_req",   32'(imemBus.imem_request), 32'd0);
    checkVal("held_pc",    debug_pc, 32'h0000_000C);
    checkVal("held_instr", id_instruction, 32'hC0DE_0008);
    tick();
    checkVal("held2_req",   32'(imemBus.imem_request), 32'd0);
    checkVal("held2_pc",    debug_pc, 32'h0000_000C);
    checkVal("held2_pc4",   id_pc_4, 32'h0000_000C);
    shouldStall = 1'b0;
    tick();
    checkVal("rel_instr", id_instruction, 32'hC0DE_000C);
    checkVal("rel_pc4",   id_pc_4, 32'h0000_0010);
    checkVal("rel_addr",  imemBus.imem_address, 32'h0000_0010);

    // Taken branch to 0x40 with ready=1.
    shouldJumpOrBranch = 1'b1;
    jumpOrBranchPc     = 32'h0000_0040;
    tick();
    shouldJumpOrBranch = 1'b0;
    checkVal("br_addr", imemBus.imem_address, 32'h0000_0040);
`ifdef BRANCH_DELAY_SLOT_EN
    checkVal("br_slot",  id_instruction, 32'hC0DE_0010);
    checkVal("br_valid", 32'(id_valid), 32'd1);
`else
    checkVal("br_valid", 32'(id_valid), 32'd0);
    checkVal("br_nop",   id_instruction, 32'h0000_0000);
`endif
    tick();
    checkVal("tgt_instr", id_instruction, 32'hC0DE_0040);
    checkVal("tgt_valid", 32'(id_valid), 32'd1);

    // Redirect to 0x80 while the fetch at 0x44 waits 3 cycles.
    imemBus.imem_ready = 1'b0;
    shouldJumpOrBranch = 1'b1;
    jumpOrBranchPc     = 32'h0000_0080;
    tick();
    shouldJumpOrBranch = 1'b0;
    checkVal("w0_addr",  imemBus.imem_address, 32'h0000_0044);
    checkVal("w0_req",   32'(imemBus.imem_request), 32'd1);
    checkVal("w0_valid", 32'(id_valid), 32'd0);
    tick();
    checkVal("w1_addr", imemBus.imem_address, 32'h0000_0044);
    tick();
    checkVal("w2_addr", imemBus.imem_address, 32'h0000_0044);
    checkVal("w2_req",  32'(imemBus.imem_request), 32'd1);
    imemBus.imem_ready = 1'b1;
    tick();
    checkVal("drn_addr", imemBus.imem_address, 32'h0000_0080);
    checkVal("drn_req",  32'(imemBus.imem_request), 32'd1);
`ifdef BRANCH_DELAY_SLOT_EN
    checkVal("drn_slot",  id_instruction, 32'hC0DE_0044);
    checkVal("drn_valid", 32'(id_valid), 32'd1);
`else
    checkVal("drn_valid", 32'(id_valid), 32'd0);
`endif
    tick();
    checkVal("t80_pc4",   id_pc_4, 32'h0000_0084);
    checkVal("t80_valid", 32'(id_valid), 32'd1);

    // Stall and branch together: no redirect until the stall drops.
    shouldStall        = 1'b1;
    shouldJumpOrBranch = 1'b1;
    jumpOrBranchPc     = 32'h0000_00C0;
    tick();
    checkVal("sb_addr", imemBus.imem_address, 32'h0000_0084);
    checkVal("sb_req",  32'(imemBus.imem_request), 32'd0);
    checkVal("sb_pc4",  id_pc_4, 32'h0000_0084);
    shouldStall = 1'b0;
    tick();
    shouldJumpOrBranch = 1'b0;
    checkVal("sbr_addr", imemBus.imem_address, 32'h0000_00C0);
    checkVal("sbr_req",  32'(imemBus.imem_request), 32'd1);
`ifdef BRANCH_DELAY_SLOT_EN
    checkVal("sbr_slot", id_instruction, 32'hC0DE_0084);
    checkVal("sbr_pc4",  id_pc_4, 32'h0000_0088);
`else
    checkVal("sbr_valid", 32'(id_valid), 32'd0);
`endif

    // Reset pulsed mid-wait.
    imemBus.imem_ready = 1'b0;
    tick();
    checkVal("mw_addr",  imemBus.imem_address, 32'h0000_00C0);
    checkVal("mw_valid", 32'(id_valid), 32'd0);
    reset = 1'b1;
    tick();
    checkVal("mwr_pc",    debug_pc, 32'h0000_0000);
    checkVal("mwr_valid", 32'(id_valid), 32'd0);
    checkVal("mwr_req",   32'(imemBus.imem_request), 32'd0);
    reset              = 1'b0;
    imemBus.imem_ready = 1'b1;
    tick();
    checkVal("rr_req", 32'(imemBus.imem_request), 32'd1);

    // PC wrap: branch to FFFF_FFFC, then +4 wraps to 0.
    tick();
    checkVal("wr_valid", 32'(id_valid), 32'd1);
    shouldJumpOrBranch = 1'b1;
    jumpOrBranchPc     = 32'hFFFF_FFFC;
    tick();
    shouldJumpOrBranch = 1'b0;
    checkVal("wr_addr", imemBus.imem_address, 32'hFFFF_FFFC);
    tick();
    checkVal("wrap_pc4",   id_pc_4, 32'h0000_0000);
    checkVal("wrap_addr",  imemBus.imem_address, 32'h0000_0000);
    checkVal("wrap_instr", id_instruction, 32'hC0DE_FFFC);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
